mc_delay_buffer: RTL and testbench

Multi-lane, programmable-depth sample delay line that delays a valid-qualified stream by `delay` accepted samples. It generalises the single-channel FIFO-based delay buffer with these additions:
- `LANES` parallel lanes share one valid.
- Delay 0 is supported.
- The delay can be reprogrammed at runtime through a load strobe with a defined refill.
- Register-array storage with explicit pointer wrap, so the depth need not be a power of two.

It sits in the FIR/correlator datapath wherever aligned multi-channel streams need fixed skew compensation.

---
 rtl/mc_delay_buffer_pkg.sv | 34 +++
 rtl/mc_delay_buffer_regfile.sv | 28 ++
 rtl/mc_delay_buffer.sv | 127 ++++++++++++
 tb/tb_mc_delay_buffer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_delay_buffer_pkg.sv
// Shared types and helpers for the multi-lane programmable delay line.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package mc_delay_buffer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } dly_state_e;

    // Output register stage count between an accepted sample and its result.
    localparam int unsigned DLY_OUT_LAT = 1;

    // Pointer minus offset, folded back into [0, depth) when it underflows.
    function automatic int unsigned ptr_sub_wrap(input int unsigned ptr,
                                                 input int unsigned d,
                                                 input int unsigned depth);
        if (ptr >= d) begin
            return ptr - d;
        end
        return ptr + depth - d;
    endfunction

    // Pointer plus one, wrapping at depth (depth need not be a power of two).
    function automatic int unsigned ptr_inc_wrap(input int unsigned ptr,
                                                 input int unsigned depth);
        if (ptr >= depth - 1) begin
            return 0;
        end
        return ptr + 1;
    endfunction

endpackage

// File: rtl/mc_delay_buffer_regfile.sv
// Register-array sample store: one synchronous write port, one combinational read port.
// Latency: write visible on the next cycle; read is same-cycle (old data on a same-address write).
// Backpressure: none, a write is accepted every cycle we_i is high.
module delay_regfile #(
    parameter int DEPTH  = 128,
    parameter int DATA_W = 128,
    parameter int AW     = 7
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Storage is never cleared: the control logic only reads freshly written entries.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mc_delay_buffer.sv
// Multi-lane delay line: outputs each accepted sample delay_q accepted samples later.
// Latency: registered output, 1 cycle after the accepted sample; delay 0 is a registered bypass.
// Backpressure: none, 1 sample/cycle; optional DELAY_BUFFER_ZERO_FILL_EN emits zeros while filling.
module mc_delay_buffer
    import mc_delay_buffer_pkg::*;
#(
    parameter  int WIDTH     = 32,
    parameter  int LANES     = 4,
    parameter  int MAX_DELAY = 128,
    localparam int DW        = $clog2(MAX_DELAY)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid_in,
    input  logic [LANES*WIDTH-1:0] data_in,
    input  logic                   flush,
    input  logic                   delay_ld,
    input  logic [DW-1:0]          delay_in,
    output logic                   valid_out,
    output logic [LANES*WIDTH-1:0] data_out,
    output logic                   primed,
    output logic [DW-1:0]          fill_count
);

    localparam int            DATA_W = LANES * WIDTH;
    localparam logic [DW-1:0] DMAX   = DW'(MAX_DELAY - 1);

    dly_state_e        state_q, state_d;
    logic [DW-1:0]     delay_q, delay_d;
    logic [DW-1:0]     cnt_q, cnt_d;
    logic [DW-1:0]     wptr_q, wptr_d;
    logic              vout_q, vout_d;
    logic [DATA_W-1:0] dout_q, dout_d;

    logic              we;
    logic [DW-1:0]     raddr;
    logic [DW-1:0]     wptr_nxt;
    logic [DW-1:0]     cnt_inc;
    logic [DATA_W-1:0] rdata;

    assign raddr    = DW'(ptr_sub_wrap(32'(wptr_q), 32'(delay_q), 32'(MAX_DELAY)));
    assign wptr_nxt = DW'(ptr_inc_wrap(32'(wptr_q), 32'(MAX_DELAY)));
    assign cnt_inc  = cnt_q + DW'(1);

    delay_regfile #(
        .DEPTH  (MAX_DELAY),
        .DATA_W (DATA_W),
        .AW     (DW)
    ) u_regfile (
        .clk     (clk),
        .we_i    (we),
        .waddr_i (wptr_q),
        .wdata_i (data_in),
        .raddr_i (raddr),
        .rdata_o (rdata)
    );

    // Next-state: flush/reload beat samples; in IDLE/FILL count toward delay_q, in RUN emit delayed data.
    always_comb begin
        state_d = state_q;
        delay_d = delay_q;
        cnt_d   = cnt_q;
        wptr_d  = wptr_q;
        vout_d  = 1'b0;
        dout_d  = dout_q;
        we      = 1'b0;
        if (flush || delay_ld) begin
            state_d = IDLE;
            cnt_d   = '0;
            wptr_d  = '0;
            if (delay_ld) begin
                delay_d = (delay_in > DMAX) ? DMAX : delay_in;
            end
        end else if (valid_in) begin
            we     = 1'b1;
            wptr_d = wptr_nxt;
            case (state_q)
                RUN: begin
                    vout_d = 1'b1;
                    // Delay 0 would read the entry being written this cycle, so bypass instead.
                    dout_d = (delay_q == '0) ? data_in : rdata;
                end
                default: begin
                    if (delay_q == '0) begin
                        state_d = RUN;
                        vout_d  = 1'b1;
                        dout_d  = data_in;
                    end else begin
                        cnt_d   = cnt_inc;
                        state_d = (cnt_inc == delay_q) ? RUN : FILL;
`ifdef DELAY_BUFFER_ZERO_FILL_EN
                        vout_d  = 1'b1;
                        dout_d  = '0;
`else
                        vout_d  = 1'b0;
`endif
                    end
                end
            endcase
        end
    end

    // State, pointer and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            delay_q <= '0;
            cnt_q   <= '0;
            wptr_q  <= '0;
            vout_q  <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            delay_q <= delay_d;
            cnt_q   <= cnt_d;
            wptr_q  <= wptr_d;
            vout_q  <= vout_d;
            dout_q  <= dout_d;
        end
    end

    assign valid_out  = vout_q;
    assign data_out   = dout_q;
    assign primed     = (state_q == RUN);
    assign fill_count = cnt_q;

endmodule

// File: tb/tb_mc_delay_buffer.sv
module tb_mc_delay_buffer;

    localparam int WIDTH = 32;
    localparam int LANES = 4;
    localparam int DATA  = WIDTH * LANES;
    localparam int HIST  = 2048;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic            vi [2];
    logic            fl [2];
    logic            ld [2];
    logic [DATA-1:0] di [2];
    logic [6:0]      dl_b;
    logic [2:0]      dl_s;
    logic            vo [2];
    logic            pr [2];
    logic [DATA-1:0] dout [2];
    logic [6:0]      fc_b;
    logic [2:0]      fc_s;

    mc_delay_buffer #(.WIDTH(WIDTH), .LANES(LANES), .MAX_DELAY(128)) u_big (
        .clk(clk), .rst(rst), .valid_in(vi[0]), .data_in(di[0]), .flush(fl[0]),
        .delay_ld(ld[0]), .delay_in(dl_b), .valid_out(vo[0]), .data_out(dout[0]),
        .primed(pr[0]), .fill_count(fc_b)
    );

    mc_delay_buffer #(.WIDTH(WIDTH), .LANES(LANES), .MAX_DELAY(5)) u_small (
        .clk(clk), .rst(rst), .valid_in(vi[1]), .data_in(di[1]), .flush(fl[1]),
        .delay_ld(ld[1]), .delay_in(dl_s), .valid_out(vo[1]), .data_out(dout[1]),
        .primed(pr[1]), .fill_count(fc_s)
    );

    int tests  = 0;
    int failed = 0;

    // Reference model: all samples accepted since the last fill start, plus the delay.
    int              m_delay [2];
    int              m_n     [2];
    logic [DATA-1:0] m_hist  [2][HIST];
    logic            m_vo    [2];
    logic [DATA-1:0] m_do    [2];

    function automatic int max_of(input int k);
        return (k == 0) ? 128 : 5;
    endfunction

    function automatic logic [DATA-1:0] ramp(input int v);
        logic [WIDTH-1:0] w;
        w = WIDTH'(v);
        return {LANES{w}};
    endfunction

    task automatic model_step(input int k, input logic r, input logic v, input logic [DATA-1:0] d,
                              input logic f, input logic l, input int din);
        if (r) begin
            m_delay[k] = 0;
            m_n[k]     = 0;
            m_vo[k]    = 1'b0;
            m_do[k]    = '0;
        end else if (f || l) begin
            if (l) m_delay[k] = (din > max_of(k) - 1) ? max_of(k) - 1 : din;
            m_n[k]  = 0;
            m_vo[k] = 1'b0;
        end else if (v) begin
            m_hist[k][m_n[k] % HIST] = d;
            m_n[k] = m_n[k] + 1;
            if (m_n[k] > m_delay[k]) begin
                m_vo[k] = 1'b1;
                m_do[k] = m_hist[k][(m_n[k] - 1 - m_delay[k]) % HIST];
            end else begin
`ifdef DELAY_BUFFER_ZERO_FILL_EN
                m_vo[k] = 1'b1;
                m_do[k] = '0;
`else
                m_vo[k] = 1'b0;
`endif
            end
        end else begin
            m_vo[k] = 1'b0;
        end
    endtask

    function automatic logic [DATA+33:0] exp_vec(input int k);
        logic p;
        int   fc;
        p  = (m_n[k] > 0) && (m_n[k] >= m_delay[k]);
        fc = (m_n[k] < m_delay[k]) ? m_n[k] : m_delay[k];
        return {m_vo[k], m_do[k], p, 32'(fc)};
    endfunction

    function automatic logic [DATA+33:0] obs_vec(input int k);
        logic [31:0] fc;
        fc = (k == 0) ? 32'(fc_b) : 32'(fc_s);
        return {vo[k], dout[k], pr[k], fc};
    endfunction

    // One clock on instance k (the other instance idles); the model follows the same inputs.
    task automatic cycle(input int k, input logic v, input logic [DATA-1:0] d,
                         input logic f, input logic l, input int din);
        for (int j = 0; j < 2; j++) begin
            vi[j] = 1'b0;
            fl[j] = 1'b0;
            ld[j] = 1'b0;
        end
        vi[k] = v;
        fl[k] = f;
        ld[k] = l;
        di[k] = d;
        if (k == 0) dl_b = 7'(din);
        else        dl_s = 3'(din);
        @(posedge clk);
        model_step(0, rst, vi[0], di[0], fl[0], ld[0], int'(dl_b));
        model_step(1, rst, vi[1], di[1], fl[1], ld[1], int'(dl_s));
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle(0, 1'b1, ramp(9), 1'b0, 1'b0, 0);
        cycle(0, 1'b0, '0, 1'b0, 1'b0, 0);
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tests++;
            if (obs_vec(k) !== {1'b0, {DATA{1'b0}}, 1'b0, 32'd0}) begin
                failed++;
                $display("FAIL reset inst%0d got=%h want=0", k, obs_vec(k));
            end
        end
    endtask

    task automatic test_ramp_delay3();
        cycle(0, 1'b0, '0, 1'b0, 1'b1, 3);
        for (int i = 1; i <= 12; i++) begin
            cycle(0, 1'b1, ramp(i), 1'b0, 1'b0, 0);
            tests++;
            if (obs_vec(0) !== exp_vec(0)) begin
                failed++;
                $display("FAIL ramp3 sample%0d got=%h want=%h", i, obs_vec(0), exp_vec(0));
            end
            if (i == 4) begin
                tests++;
                if (vo[0] !== 1'b1 || dout[0] !== ramp(1)) begin
                    failed++;
                    $display("FAIL ramp3_first_out got vo=%b d=%h want vo=1 d=%h", vo[0], dout[0], ramp(1));
                end
            end
        end
    endtask

    task automatic test_delay0();
        cycle(0, 1'b0, '0, 1'b0, 1'b1, 0);
        cycle(0, 1'b1, ramp(32'hA5), 1'b0, 1'b0, 0);
        tests++;
        if (vo[0] !== 1'b1 || dout[0] !== ramp(32'hA5) || pr[0] !== 1'b1) begin
            failed++;
            $display("FAIL delay0 got vo=%b d=%h pr=%b want vo=1 d=%h pr=1", vo[0], dout[0], pr[0], ramp(32'hA5));
        end
        cycle(0, 1'b0, '0, 1'b0, 1'b0, 0);
        tests++;
        if (vo[0] !== 1'b0 || dout[0] !== ramp(32'hA5)) begin
            failed++;
            $display("FAIL delay0_hold got vo=%b d=%h want vo=0 d=%h", vo[0], dout[0], ramp(32'hA5));
        end
    endtask

    task automatic test_gapped();
        cycle(0, 1'b0, '0, 1'b0, 1'b1, 2);
        for (int i = 0; i < 30; i++) begin
            cycle(0, (i % 3) == 0, ramp(100 + i), 1'b0, 1'b0, 0);
            tests++;
            if (obs_vec(0) !== exp_vec(0)) begin
                failed++;
                $display("FAIL gapped cyc%0d got=%h want=%h", i, obs_vec(0), exp_vec(0));
            end
        end
    endtask

    task automatic test_clamp_wrap();
        cycle(1, 1'b0, '0, 1'b0, 1'b1, 7);
        for (int i = 1; i <= 20; i++) begin
            cycle(1, 1'b1, ramp(i), 1'b0, 1'b0, 0);
            tests++;
            if (obs_vec(1) !== exp_vec(1)) begin
                failed++;
                $display("FAIL wrap sample%0d got=%h want=%h", i, obs_vec(1), exp_vec(1));
            end
            if (i == 5) begin
                tests++;
                if (dout[1] !== ramp(1) || fc_s !== 3'd4) begin
                    failed++;
                    $display("FAIL clamp got d=%h fc=%0d want d=%h fc=4", dout[1], fc_s, ramp(1));
                end
            end
        end
    endtask

    task automatic test_flush_reload();
        cycle(0, 1'b0, '0, 1'b0, 1'b1, 4);
        for (int i = 0; i < 22; i++) begin
            if (i == 8)       cycle(0, 1'b1, ramp(500 + i), 1'b1, 1'b0, 0);
            else if (i == 15) cycle(0, 1'b1, ramp(500 + i), 1'b0, 1'b1, 1);
            else              cycle(0, 1'b1, ramp(500 + i), 1'b0, 1'b0, 0);
            tests++;
            if (obs_vec(0) !== exp_vec(0)) begin
                failed++;
                $display("FAIL flush cyc%0d got=%h want=%h", i, obs_vec(0), exp_vec(0));
            end
            if (i == 8 || i == 15) begin
                tests++;
                if (pr[0] !== 1'b0) begin
                    failed++;
                    $display("FAIL flush_primed cyc%0d got=%b want=0", i, pr[0]);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            int k;
            k = int'($urandom_range(0, 1));
            cycle(k, ($urandom % 4) != 0, {$urandom, $urandom, $urandom, $urandom},
                  ($urandom % 23) == 0, ($urandom % 29) == 0,
                  (k == 0) ? int'($urandom_range(0, 10)) : int'($urandom_range(0, 7)));
            for (int j = 0; j < 2; j++) begin
                tests++;
                if (obs_vec(j) !== exp_vec(j)) begin
                    failed++;
                    $display("FAIL random cyc%0d inst%0d got=%h want=%h", i, j, obs_vec(j), exp_vec(j));
                end
            end
        end
    endtask

    initial begin
        rst  = 1'b1;
        dl_b = '0;
        dl_s = '0;
        for (int j = 0; j < 2; j++) begin
            vi[j]      = 1'b0;
            fl[j]      = 1'b0;
            ld[j]      = 1'b0;
            di[j]      = '0;
            m_delay[j] = 0;
            m_n[j]     = 0;
            m_vo[j]    = 1'b0;
            m_do[j]    = '0;
        end
        test_reset();
        test_ramp_delay3();
        test_delay0();
        test_gapped();
        test_clamp_wrap();
        test_flush_reload();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
